// File: rtl/seg_scan_decoder_pkg.sv
// seg_scan_decoder_pkg: segment patterns, anode selects and FSM encoding shared by the scan decoder
package seg_scan_decoder_pkg;

    // Active-low cathode patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    // Indexed by digit value
    localparam logic [9:0][6:0] SEG_TABLE = {SEG_9, SEG_8, SEG_7, SEG_6, SEG_5,
                                             SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};

    localparam logic [6:0] CATH_IDLE = 7'b1111111;

    // Active-low one-hot digit selects; inverting one gives its capture mask
    localparam logic [3:0] AN_D0   = 4'b1110;
    localparam logic [3:0] AN_D1   = 4'b1101;
    localparam logic [3:0] AN_D2   = 4'b1011;
    localparam logic [3:0] AN_D3   = 4'b0111;
    localparam logic [3:0] AN_IDLE = 4'b1111;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// seg_pattern_decode: combinational cathode pattern to BCD digit lookup with a valid flag
module seg_pattern_decode
    import seg_scan_decoder_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] digit_o,
    output logic       valid_o
);

    // Match against the ten legal patterns; anything else is undecodable
    always_comb begin
        digit_o = 4'd0;
        valid_o = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (seg_i == SEG_TABLE[i]) begin
                digit_o = 4'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers a 4-digit value from a multiplexed 7-segment scan; SEG_SCAN_BIN_CONV_EN adds BCD-to-binary conversion
module seg_scan_decoder
    import seg_scan_decoder_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  seg_anode,
    input  logic [6:0]  seg_cathode,
    output logic [15:0] bcd_out,
    output logic [13:0] bin_out,
    output logic        frame_valid,
    output logic        seg_error
);

    logic [3:0]       anode_q;
    logic [6:0]       cath_q;
    logic [8:0]       cnt_q, cnt_d;
    logic [3:0]       flag_q, flag_d, cap;
    logic [3:0][3:0]  dig_q;
    state_t           state_q, state_d;
    logic [15:0]      bcd_q;
    logic             fv_q;
    logic             accept, an_valid, leave, bad;
    logic [3:0]       dec_digit;
    logic             dec_valid;
`ifdef SEG_SCAN_BIN_CONV_EN
    logic [3:0][3:0]  snap_q;
    logic [13:0]      acc_q, acc_d, bin_q;
    logic [1:0]       step_q;
`endif

    seg_pattern_decode u_decode (
        .seg_i   (cath_q),
        .digit_o (dec_digit),
        .valid_o (dec_valid)
    );

    // Dwell stability counting, acceptance and digit capture masks; the counter
    // saturates above any legal STABLE_CYCLES so a long dwell is accepted once
    always_comb begin
        cnt_d    = ({seg_anode, seg_cathode} != {anode_q, cath_q}) ? 9'd1
                 : (cnt_q == 9'd256) ? cnt_q : cnt_q + 9'd1;
        accept   = cnt_q == 9'(STABLE_CYCLES);
        an_valid = anode_q == AN_D0 || anode_q == AN_D1 || anode_q == AN_D2 || anode_q == AN_D3;
        cap      = (accept && an_valid && dec_valid) ? ~anode_q : 4'b0000;
        bad      = accept && an_valid && !dec_valid;
        leave    = state_q == COLLECT && &flag_q;
        flag_d   = (leave ? 4'b0000 : flag_q) | cap;
`ifdef SEG_SCAN_BIN_CONV_EN
        acc_d    = acc_q * 14'd10 + {10'd0, snap_q[2'd3 - step_q]};
`endif
    end

    // Frame sequencing: collect four digits, optionally convert, then publish
    always_comb begin
        state_d = state_q;
`ifdef SEG_SCAN_BIN_CONV_EN
        state_d = (state_q == COLLECT) ? (&flag_q ? CONVERT : COLLECT)
                : (state_q == CONVERT) ? ((step_q == 2'd3) ? DONE : CONVERT)
                : COLLECT;
`else
        state_d = leave ? DONE : COLLECT;
`endif
    end

    // State, input sampling, digit collection and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
            anode_q <= AN_IDLE;
            cath_q  <= CATH_IDLE;
            cnt_q   <= 9'd0;
            flag_q  <= 4'b0000;
            dig_q   <= '0;
            bcd_q   <= 16'd0;
            fv_q    <= 1'b0;
`ifdef SEG_SCAN_BIN_CONV_EN
            snap_q  <= '0;
            acc_q   <= 14'd0;
            step_q  <= 2'd0;
            bin_q   <= 14'd0;
`endif
        end else begin
            state_q <= state_d;
            anode_q <= seg_anode;
            cath_q  <= seg_cathode;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
            fv_q    <= state_d == DONE;
            for (int i = 0; i < 4; i++)
                if (cap[i]) dig_q[i] <= dec_digit;
`ifdef SEG_SCAN_BIN_CONV_EN
            if (leave) begin
                snap_q <= dig_q;
                acc_q  <= 14'd0;
                step_q <= 2'd0;
            end else if (state_q == CONVERT) begin
                acc_q  <= acc_d;
                step_q <= step_q + 2'd1;
            end
            if (state_q == CONVERT && state_d == DONE) begin
                bcd_q <= snap_q;
                bin_q <= acc_d;
            end
`else
            if (leave) bcd_q <= dig_q;
`endif
        end
    end

    assign bcd_out     = bcd_q;
    assign frame_valid = fv_q & ~rst;
    assign seg_error   = bad & ~rst;
`ifdef SEG_SCAN_BIN_CONV_EN
    assign bin_out     = bin_q;
`else
    assign bin_out     = 14'd0;
`endif

endmodule
